// File: rtl/spi_param_decoder.sv
// spi_param_decoder: decodes SPI header/payload words into per-motor Kp/Ki gain registers.
// Define SPI_PARAM_DECODER_READBACK_EN to build the 0x02/0x03 readback path (LOAD state).
module spi_param_decoder #(
  parameter int NUMBER_OF_MOTORS = 4,
  parameter logic [15:0] TIMEOUT = 16'd4096
) (
  input  logic iCLK,
  input  logic iRESET,
  input  logic iDO_VALID,
  input  logic [31:0] iDO,
  input  logic iSSEL,
  output logic [31:0] oDI,
  output logic oWREN,
  input  logic iWR_ACK,
  output logic [32*NUMBER_OF_MOTORS-1:0] oKP,
  output logic [32*NUMBER_OF_MOTORS-1:0] oKI,
  output logic [NUMBER_OF_MOTORS-1:0] oUPDATE,
  output logic [7:0] oERR_CNT
);
  localparam int IW = NUMBER_OF_MOTORS > 1 ? $clog2(NUMBER_OF_MOTORS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT_DATA, LOAD} stateT;
  stateT state;
  logic [1:0] rstSync;
  logic [31:0] kp [NUMBER_OF_MOTORS];
  logic [31:0] ki [NUMBER_OF_MOTORS];
  logic [15:0] tmr;
  logic [IW-1:0] idxQ;
  logic wrKi;
  logic [7:0] cmd;
  logic [IW-1:0] idxIn;
  logic accept, idxOk, isWr, isRd, hdrOk, err, unusedBits;
  assign cmd = iDO[31:24];
  assign idxIn = iDO[IW-1:0];
  assign unusedBits = ^{iDO[23:8], iWR_ACK};
  assign accept = iDO_VALID && !rstSync[1];
  assign idxOk = {1'b0, iDO[7:0]} < 9'(NUMBER_OF_MOTORS);
  assign isWr = cmd == 8'h00 || cmd == 8'h01;
`ifdef SPI_PARAM_DECODER_READBACK_EN
  assign isRd = cmd == 8'h02 || cmd == 8'h03;
`else
  assign isRd = 1'b0;
  assign oDI = '0;
  assign oWREN = 1'b0;
`endif
  assign hdrOk = accept && idxOk && (isWr || isRd);
  // A payload or acknowledge arriving with iSSEL high still completes cleanly.
  assign err = state == IDLE ? accept && !hdrOk
             : state == WAIT_DATA ? !iDO_VALID && (iSSEL || tmr == TIMEOUT - 16'd1)
             : iDO_VALID || (!iWR_ACK && iSSEL);
  for (genvar n = 0; n < NUMBER_OF_MOTORS; n++) begin : g_flat
    assign oKP[32*n +: 32] = kp[n];
    assign oKI[32*n +: 32] = ki[n];
  end
  always_ff @(posedge iCLK or posedge iRESET)
    if (iRESET) begin
      state <= IDLE;
      rstSync <= 2'b11;
      tmr <= '0;
      idxQ <= '0;
      wrKi <= 1'b0;
      oUPDATE <= '0;
      oERR_CNT <= '0;
`ifdef SPI_PARAM_DECODER_READBACK_EN
      oDI <= '0;
      oWREN <= 1'b0;
`endif
      for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
        kp[i] <= '0;
        ki[i] <= '0;
      end
    end else begin
      rstSync <= {rstSync[0], 1'b0};
      oUPDATE <= '0;
      if (err && oERR_CNT != 8'hFF) oERR_CNT <= oERR_CNT + 8'd1;
      case (state)
        IDLE: if (hdrOk) begin
          idxQ <= idxIn;
          wrKi <= cmd[0];
          tmr <= '0;
          if (isWr) state <= WAIT_DATA;
`ifdef SPI_PARAM_DECODER_READBACK_EN
          if (isRd) begin
            oDI <= cmd[0] ? ki[idxIn] : kp[idxIn];
            oWREN <= 1'b1;
            state <= LOAD;
          end
`endif
        end
        WAIT_DATA: begin
          tmr <= tmr + 16'd1;
          if (iDO_VALID) begin
            if (wrKi) ki[idxQ] <= iDO;
            else kp[idxQ] <= iDO;
            oUPDATE[idxQ] <= 1'b1;
            state <= IDLE;
          end else if (iSSEL || tmr == TIMEOUT - 16'd1) state <= IDLE;
        end
        default: begin
`ifdef SPI_PARAM_DECODER_READBACK_EN
          if (iWR_ACK || iSSEL) begin
            oWREN <= 1'b0;
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
      endcase
    end
endmodule

// File: doc/spi_param_decoder.md
SPI_PARAM_DECODER -- requirements
Module: spi_param_decoder

Interface
REQ-001 Parameter NUMBER_OF_MOTORS, default 4: number of gain register pairs, range 1..256.
REQ-002 Parameter TIMEOUT, default 16'd4096: maximum iCLK cycles allowed between a header word and its payload word.
REQ-003 iCLK  in  1  system clock; the only clock in the block.
REQ-004 iRESET  in  1  reset, asynchronous, active-high.
REQ-005 iDO_VALID  in  1  one-cycle pulse from the SPI slave marking a received word on iDO.
REQ-006 iDO  in  32  received SPI word.
REQ-007 iSSEL  in  1  SPI slave select, active-low; high means no frame is in progress.
REQ-008 oDI  out  32  readback word presented to the SPI slave.
REQ-009 oWREN  out  1  request for the SPI slave to load oDI.
REQ-010 iWR_ACK  in  1  one-cycle acknowledge from the SPI slave that oDI was loaded.
REQ-011 oKP  out  32*NUMBER_OF_MOTORS  flattened Kp registers; motor n occupies bits [32n+31:32n].
REQ-012 oKI  out  32*NUMBER_OF_MOTORS  flattened Ki registers, same layout as oKP.
REQ-013 oUPDATE  out  NUMBER_OF_MOTORS  one-cycle pulse per motor whenever that motor's Kp or Ki is written.
REQ-014 oERR_CNT  out  8  saturating protocol error counter.

Function
REQ-015 States: IDLE, WAIT_DATA, LOAD.
REQ-016 In IDLE, a header word is accepted on iDO_VALID: cmd = iDO[31:24], idx = iDO[7:0].
REQ-017 Commands: 0x00 writes Kp, 0x01 writes Ki, 0x02 reads Kp, 0x03 reads Ki.
REQ-018 Any other cmd, or idx >= NUMBER_OF_MOTORS, increments oERR_CNT and the FSM stays in IDLE.
REQ-019 A valid write header latches cmd and idx, clears the timeout counter and enters WAIT_DATA.
REQ-020 In WAIT_DATA, the next iDO_VALID writes iDO into Kp[idx] or Ki[idx] on that clock edge; oUPDATE[idx] pulses high the following cycle; the FSM returns to IDLE.
REQ-021 A valid read header drives oDI with the selected register on the next cycle, asserts oWREN and enters LOAD.
REQ-022 In LOAD, oDI and oWREN are held stable until iWR_ACK; the FSM then deasserts oWREN the next cycle and returns to IDLE.
REQ-023 iDO_VALID received in LOAD is ignored and counted as an error.
REQ-024 WAIT_DATA timeout: the counter increments every cycle; on reaching TIMEOUT the FSM returns to IDLE and oERR_CNT increments; no register is written.
REQ-025 A cycle with iSSEL high while in WAIT_DATA or LOAD aborts to IDLE, increments oERR_CNT and deasserts oWREN.
REQ-026 If iDO_VALID and iSSEL high occur in the same cycle in WAIT_DATA, the payload is written and no error is counted.
REQ-027 If iWR_ACK and iSSEL high occur in the same cycle in LOAD, the read completes and no error is counted.
REQ-028 oERR_CNT saturates at 8'hFF and does not wrap.
REQ-029 At most one error increment per cycle.
REQ-030 oKP and oKI change only via REQ-020; they are driven directly from registers with zero combinational path from inputs.

Reset
REQ-031 iRESET high asynchronously forces: state IDLE; all Kp and Ki registers 0; oDI 0; oWREN 0; oUPDATE 0; oERR_CNT 0; timeout counter 0.
REQ-032 Reset asserted mid-transaction discards the latched header; no partial write occurs.
REQ-033 Reset deassertion is synchronised internally; the first header is accepted no earlier than the second iCLK edge after deassertion.

Configuration
REQ-034 Macro SPI_PARAM_DECODER_READBACK_EN defined: read commands 0x02 and 0x03 behave per REQ-021 and REQ-022.
REQ-035 Macro SPI_PARAM_DECODER_READBACK_EN undefined: LOAD state and readback mux are not built; commands 0x02 and 0x03 are treated as invalid per REQ-018; oDI is tied to 0 and oWREN to 0.

Verification
REQ-036 Header 0x00000002 then payload 0x12345678, iSSEL low -> oKP[95:64]=0x12345678; oUPDATE=4'b0100 for exactly one cycle; oERR_CNT=0.
REQ-037 Header 0x01000007 with NUMBER_OF_MOTORS=4 -> oERR_CNT=1; state IDLE; no register changes.
REQ-038 Ki[1] preloaded with 0xCAFEF00D; header 0x03000001; iWR_ACK held off for 10 cycles -> oWREN high with oDI=0xCAFEF00D stable for 10 cycles, low one cycle after the acknowledge (readback macro defined).
REQ-039 Header 0x00000000, then no payload for TIMEOUT cycles -> FSM returns to IDLE; oERR_CNT=1; Kp[0] unchanged; a subsequent header/payload pair succeeds.
REQ-040 Header 0x00000001, then iSSEL high together with payload 0xAAAA5555 -> Kp[1]=0xAAAA5555 and no error; repeating with iSSEL high one cycle before the payload -> abort, oERR_CNT increments, Kp[1] unchanged.
REQ-041 300 invalid headers -> oERR_CNT=0xFF; iRESET pulse mid-WAIT_DATA -> all outputs 0 immediately, without waiting for a clock edge.
